// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
//
// Purpose : FSM state and owner encodings, doubleword geometry, and the
//           alignment helper used by dmem_arbiter and dmem_arb_pick.
// Ports   : none (package)

package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    CORE = 1'b0,
    DBG  = 1'b1
  } owner_t;

  localparam int DW_BYTES   = 8;
  localparam int ALIGN_BITS = 3;

  // A doubleword access is legal only on an 8-byte boundary.
  function automatic logic is_misaligned(input logic [ALIGN_BITS-1:0] i_lsb);
    return |i_lsb;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - two-way grant decision with dbg starvation guard
//
// Purpose : Chooses the owner of the next memory access. Core has priority,
//           but once MAX_WAIT core grants have been made back-to-back while
//           dbg was waiting, dbg is forced through on the next decision.
// Ports   :
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   i_core_req in   core request
//   i_dbg_req  in   dbg request
//   i_grant_en in   a grant is being taken this cycle (arbiter idle, req seen)
//   o_owner    out  requester that wins if a grant is taken (combinational)

module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_core_req,
  input  logic   i_dbg_req,
  input  logic   i_grant_en,
  output owner_t o_owner
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0] r_wait_cnt;
  logic       w_force_dbg;

  assign w_force_dbg = (r_wait_cnt == WAIT_MAX);

  // dbg wins when it is alone, or when core has had its full run of grants.
  always_comb begin
    o_owner = CORE;
    if (i_dbg_req && (!i_core_req || w_force_dbg)) begin
      o_owner = DBG;
    end
  end

  // Count only core grants that actually made dbg wait; saturate so the
  // force condition stays asserted until dbg is served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
    end else if (i_grant_en) begin
      if (o_owner == DBG) begin
        r_wait_cnt <= 4'd0;
      end else if (i_dbg_req && !w_force_dbg) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data-memory arbiter and access sequencer
//
// Purpose : Shares one doubleword data memory between the pipeline MEM stage
//           (core) and a debug/loader port (dbg). One access in flight at a
//           time: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP -> IDLE.
//           Misaligned requests skip the memory and go IDLE -> RESP with err.
// Ports   :
//   clk, rst                       clock, asynchronous active-high reset
//   core_req/we/addr/wdata    in   core request, held until core_done
//   core_stall                out  core_req & ~core_done (combinational)
//   core_done/err/rdata       out  completion pulse, misalign flag, load data
//   dbg_req/we/addr/wdata     in   dbg request, same protocol as core
//   dbg_done/err/rdata        out  dbg completion, same protocol as core
//   mem_en/we/addr/wdata      out  memory strobe and registered access fields
//   mem_rdata                 in   read data, valid MEM_LAT cycles after mem_en
//   busy                      out  sequencer not idle

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 64,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic              core_done,
  output logic              core_err,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_done,
  output logic              dbg_err,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  owner_t            w_pick;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic [2:0]        r_lat_cnt;
  logic [DATA_W-1:0] r_core_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic              w_any_req;
  logic              w_grant_en;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_mis;
  logic              w_resp;

  assign w_any_req  = core_req | dbg_req;
  assign w_grant_en = (r_state == IDLE) && w_any_req;

  dmem_arb_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .clk        (clk),
    .rst        (rst),
    .i_core_req (core_req),
    .i_dbg_req  (dbg_req),
    .i_grant_en (w_grant_en),
    .o_owner    (w_pick)
  );

  // Request fields of whichever side the picker selects.
  assign w_sel_we    = (w_pick == DBG) ? dbg_we    : core_we;
  assign w_sel_addr  = (w_pick == DBG) ? dbg_addr  : core_addr;
  assign w_sel_wdata = (w_pick == DBG) ? dbg_wdata : core_wdata;
  assign w_mis       = is_misaligned(w_sel_addr[ALIGN_BITS-1:0]);

  // Next state and all strobes; strobes depend on state only so reset
  // forces them low immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_resp      = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    core_done   = 1'b0;
    core_err    = 1'b0;
    dbg_done    = 1'b0;
    dbg_err     = 1'b0;
    busy        = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = w_mis ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mem_en      = 1'b1;
        mem_we      = r_we;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_lat_cnt == 3'd1) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_resp      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_resp) begin
      if (r_owner == DBG) begin
        dbg_done = 1'b1;
        dbg_err  = r_err;
      end else begin
        core_done = 1'b1;
        core_err  = r_err;
      end
    end
  end

  assign core_stall = core_req & ~core_done;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign core_rdata = r_core_rdata;
  assign dbg_rdata  = r_dbg_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= CORE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      r_lat_cnt    <= 3'd0;
      r_core_rdata <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner <= w_pick;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_err   <= w_mis;
            // A rejected access reports zero data alongside its err flag.
            if (w_mis) begin
              if (w_pick == DBG) begin
                r_dbg_rdata <= '0;
              end else begin
                r_core_rdata <= '0;
              end
            end
          end
        end
        ISSUE: begin
          r_lat_cnt <= LAT_INIT;
        end
        WAIT: begin
          r_lat_cnt <= r_lat_cnt - 3'd1;
          // Last WAIT cycle lines up with mem_rdata being valid.
          if ((r_lat_cnt == 3'd1) && !r_we) begin
            if (r_owner == DBG) begin
              r_dbg_rdata <= mem_rdata;
            end else begin
              r_core_rdata <= mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter at MEM_LAT 1 and 3

module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Index 0: MEM_LAT=1, index 1: MEM_LAT=3.
  logic [1:0]        core_req, core_we, dbg_req, dbg_we;
  logic [1:0][9:0]   core_addr, dbg_addr, mem_addr;
  logic [1:0][63:0]  core_wdata, dbg_wdata, core_rdata, dbg_rdata;
  logic [1:0][63:0]  mem_wdata, mem_rdata;
  logic [1:0]        core_stall, core_done, core_err, dbg_done, dbg_err;
  logic [1:0]        mem_en, mem_we, busy;

  function automatic logic [63:0] init_val(input int i);
    return 64'h1122334455667788 ^ (64'(i ^ 2) * 64'h0001000100010001);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [63:0] mem_arr [128];
    bit          wr_v    [128];
    logic [63:0] pd      [LAT];
    bit          pv      [LAT];

    dmem_arbiter #(.ADDR_W(10), .DATA_W(64), .MEM_LAT(LAT), .MAX_WAIT(4)) u_dut (
      .clk(clk), .rst(rst),
      .core_req(core_req[g]), .core_we(core_we[g]), .core_addr(core_addr[g]),
      .core_wdata(core_wdata[g]), .core_stall(core_stall[g]), .core_done(core_done[g]),
      .core_err(core_err[g]), .core_rdata(core_rdata[g]),
      .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]),
      .dbg_wdata(dbg_wdata[g]), .dbg_done(dbg_done[g]), .dbg_err(dbg_err[g]),
      .dbg_rdata(dbg_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );

    // Data is only valid in the single cycle LAT after mem_en; poison otherwise.
    assign mem_rdata[g] = pv[LAT-1] ? pd[LAT-1] : 64'hBADDBADDBADDBADD;

    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) begin
        mem_arr[mem_addr[g][9:3]] <= mem_wdata[g];
        wr_v[mem_addr[g][9:3]]    <= 1'b1;
      end
      pv[0] <= mem_en[g] && !mem_we[g];
      pd[0] <= wr_v[mem_addr[g][9:3]] ? mem_arr[mem_addr[g][9:3]]
                                      : init_val(int'(mem_addr[g][9:3]));
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard and reference model.
  typedef struct {
    int          inst;
    bit          dbg;
    bit          err;
    logic [63:0] rd;
    int          dc;
  } exp_t;

  exp_t        sb [$];
  logic [63:0] ref_mem  [2][128];
  logic [63:0] m_core_rd [2];
  logic [63:0] m_dbg_rd  [2];

  task automatic expect_of(input int k, input bit d, input bit we, input logic [9:0] a,
                           input logic [63:0] wd, output logic [63:0] r);
    if (a[2:0] != 3'd0) r = '0;
    else if (we) begin
      ref_mem[k][a[9:3]] = wd;
      r = d ? m_dbg_rd[k] : m_core_rd[k];
    end else r = ref_mem[k][a[9:3]];
    if (d) m_dbg_rd[k] = r;
    else   m_core_rd[k] = r;
  endtask

  task automatic push_exp(input int k, input bit d, input bit we, input logic [9:0] a,
                          input logic [63:0] wd, input int dc);
    exp_t x;
    logic [63:0] r;
    expect_of(k, d, we, a, wd, r);
    x.inst = k; x.dbg = d; x.err = (a[2:0] != 3'd0); x.rd = r; x.dc = dc;
    sb.push_back(x);
  endtask

  task automatic pop_cmp(input int k, input bit d, input logic e, input logic [63:0] rd);
    exp_t x;
    if (sb.size() == 0) begin
      check("done_without_request", 64'(sb.size()), 64'd1);
      return;
    end
    x = sb.pop_front();
    check("done_inst",  64'(k),   64'(x.inst));
    check("done_owner", 64'(d),   64'(x.dbg));
    check("done_cycle", 64'(cyc), 64'(x.dc));
    check("done_err",   64'(e),   64'(x.err));
    check("done_rdata", rd,       x.rd);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (core_done[k]) pop_cmp(k, 1'b0, core_err[k], core_rdata[k]);
        if (dbg_done[k])  pop_cmp(k, 1'b1, dbg_err[k],  dbg_rdata[k]);
      end
    end
  end

  task automatic drive(input int k, input bit d, input bit we, input logic [9:0] a,
                       input logic [63:0] wd);
    if (d) begin
      dbg_req[k] = 1'b1; dbg_we[k] = we; dbg_addr[k] = a; dbg_wdata[k] = wd;
    end else begin
      core_req[k] = 1'b1; core_we[k] = we; core_addr[k] = a; core_wdata[k] = wd;
    end
  endtask

  // Called #1 after a posedge with the DUT idle; returns #1 into the next idle cycle.
  task automatic access(input int k, input bit d, input bit we, input logic [9:0] a,
                        input logic [63:0] wd, input string tag);
    int lat;
    bit mis;
    int t;
    int dc;
    lat = (k == 0) ? 1 : 3;
    mis = (a[2:0] != 3'd0);
    t   = cyc;
    dc  = mis ? t + 1 : t + 2 + lat;
    push_exp(k, d, we, a, wd, dc);
    drive(k, d, we, a, wd);
    #1;
    if (!d) check({tag, "_stall_pending"}, 64'(core_stall[k]), 64'd1);
    while (cyc < dc) begin
      @(posedge clk); #1;
      if (cyc == t + 1) begin
        check({tag, "_mem_en"}, 64'(mem_en[k]), 64'(!mis));
        if (!mis) begin
          check({tag, "_mem_we"},   64'(mem_we[k]),   64'(we));
          check({tag, "_mem_addr"}, 64'(mem_addr[k]), 64'(a));
          if (we) check({tag, "_mem_wdata"}, mem_wdata[k], wd);
        end
      end
      if (cyc == t + 2 && !mis) check({tag, "_mem_en_single"}, 64'(mem_en[k]), 64'd0);
    end
    if (!d) check({tag, "_stall_at_done"}, 64'(core_stall[k]), 64'd0);
    if (d) dbg_req[k] = 1'b0;
    else   core_req[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int t0;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    dbg_req  = '0; dbg_we  = '0; dbg_addr  = '0; dbg_wdata  = '0;
    for (int k = 0; k < 2; k++) begin
      m_core_rd[k] = '0;
      m_dbg_rd[k]  = '0;
      for (int i = 0; i < 128; i++) ref_mem[k][i] = init_val(i);
    end

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_busy",       64'(busy[k]),      64'd0);
      check("rst_mem_en",     64'(mem_en[k]),    64'd0);
      check("rst_mem_addr",   64'(mem_addr[k]),  64'd0);
      check("rst_core_done",  64'(core_done[k]), 64'd0);
      check("rst_core_rdata", core_rdata[k],     64'd0);
      check("rst_dbg_rdata",  dbg_rdata[k],      64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic load, dbg store then core readback, misaligned reject.
    access(0, 1'b0, 1'b0, 10'h010, 64'd0, "t1_load");
    access(0, 1'b1, 1'b1, 10'h008, 64'hDEADBEEFCAFEF00D, "t2_dbg_store");
    access(0, 1'b0, 1'b0, 10'h008, 64'd0, "t2_core_load");
    access(0, 1'b0, 1'b0, 10'h00C, 64'd0, "t4_misaligned");
    access(0, 1'b1, 1'b0, 10'h010, 64'd0, "dbg_load");
    access(0, 1'b0, 1'b1, 10'h030, 64'h0123456789ABCDEF, "core_store");
    access(0, 1'b1, 1'b0, 10'h030, 64'd0, "dbg_readback");

    // Starvation guard: both held, grants CCCCD CCCCD, each 4 cycles at MEM_LAT=1.
    t0 = cyc;
    drive(0, 1'b0, 1'b0, 10'h018, 64'd0);
    drive(0, 1'b1, 1'b0, 10'h020, 64'd0);
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) push_exp(0, 1'b1, 1'b0, 10'h020, 64'd0, t0 + 3 + 4 * i);
      else            push_exp(0, 1'b0, 1'b0, 10'h018, 64'd0, t0 + 3 + 4 * i);
    end
    while (cyc < t0 + 3 + 4 * 9) begin
      @(posedge clk); #1;
    end
    core_req[0] = 1'b0;
    dbg_req[0]  = 1'b0;
    @(posedge clk); #1;

    // Async reset in WAIT of a core load: outputs drop at once, no done, late data ignored.
    drive(0, 1'b0, 1'b0, 10'h010, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_busy_in_wait", 64'(busy[0]), 64'd1);
    core_req[0] = 1'b0;
    rst = 1'b1;
    #1;
    check("t5_rst_busy",       64'(busy[0]),      64'd0);
    check("t5_rst_mem_addr",   64'(mem_addr[0]),  64'd0);
    check("t5_rst_core_done",  64'(core_done[0]), 64'd0);
    check("t5_rst_core_rdata", core_rdata[0],     64'd0);
    m_core_rd[0] = '0;
    m_dbg_rd[0]  = '0;
    m_core_rd[1] = '0;
    m_dbg_rd[1]  = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t5_no_late_capture", core_rdata[0], 64'd0);
    access(0, 1'b0, 1'b0, 10'h010, 64'd0, "t5_after_rst");

    // MEM_LAT=3 back-to-back loads: dones 6 cycles apart.
    access(1, 1'b0, 1'b0, 10'h000, 64'd0, "t6_load0");
    access(1, 1'b0, 1'b0, 10'h008, 64'd0, "t6_load1");
    access(1, 1'b1, 1'b0, 10'h011, 64'd0, "dbg_misaligned");
    access(1, 1'b1, 1'b1, 10'h3F8, 64'hA5A5A5A55A5A5A5A, "dbg_store_top");
    access(1, 1'b0, 1'b0, 10'h3F8, 64'd0, "core_load_top");

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule
